alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Upstream control and operand stage for the 4-bit ALU in BasicCPU.
- Accepts 12-bit instructions over a valid/ready handshake and holds a 4-entry x 4-bit register file.
- Drives the ALU operand and select inputs, captures the ALU result into the destination register, and streams OUT results downstream over a second valid/ready handshake.
- One instruction in flight at a time.

Parameters:
- DATA_W, 4, datapath and register width. Matches the ALU; only 4 is supported.
- NREGS, 4, register-file depth. Fixed by the 2-bit register fields.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction available
- in_ready  output  1  sequencer can accept an instruction
- instr  input  12  [11:10] kind (00 ALU, 01 LOADI, 10 OUT, 11 NOP); [9:7] sel; [6] cin; [5:4] rd; [3:2] ra; [1:0] rb; LOADI immediate = [3:0]
- alu_a  output  4  ALU operand a = R[ra]
- alu_b  output  4  ALU operand b = R[rb]
- alu_s  output  3  ALU select; wired as alu_s[2] to s[0], alu_s[1] to s[1], alu_s[0] to s[2]
- alu_cin  output  1  ALU carry-in / logic select
- alu_f  input  4  ALU result (combinational)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  4  register value from an OUT instruction
- zero_flag  output  1  see Optional Feature
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; R0..R3 = 0; alu_a, alu_b, alu_s, alu_cin, out_data, out_valid, zero_flag all 0; in_ready = 1.
- FSM states: IDLE, EXEC, WB, OUTW.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch instr.
  - Next state: ALU -> EXEC; LOADI -> WB; OUT -> OUTW; NOP -> IDLE (no state change).
- EXEC:
  - alu_a = R[ra], alu_b = R[rb], alu_s = sel, alu_cin = cin, all registered and held stable for the full cycle.
  - Next state: WB.
- WB:
  - ALU kind: R[rd] <= alu_f.
  - LOADI: R[rd] <= instr[3:0].
  - Next state: IDLE.
- OUTW:
  - out_data = R[rb]; out_valid = 1; hold both until out_ready.
  - On out_valid & out_ready: out_valid <= 0, next state IDLE.
- Latency from accept to register write: ALU 2 cycles, LOADI 1 cycle. Throughput: one ALU op per 3 cycles (in_ready is low during EXEC and WB).
- in_ready is low in every state except IDLE. in_valid is ignored when in_ready is low.
- ALU outputs hold their last driven values outside EXEC.
- rd equal to ra or rb: operands are sampled in EXEC and the write occurs in WB, so the old value is used.
- Writes are plain 4-bit; the result wraps and no carry out is kept.
- OUT stall: out_ready held low keeps the block in OUTW indefinitely; out_data stays stable.
- Reset mid-operation (any state): immediate return to reset values; the pending write or output is discarded.

Optional Feature:
- Macro: ALU_SEQ_ZFLAG_EN.
- Defined:
  - zero_flag is a register updated in WB of ALU-kind instructions only: 1 when alu_f == 0.
  - LOADI, OUT and NOP leave it unchanged.
  - Reset value 0.
- Undefined: zero_flag is tied to 0 and no flag register is synthesized.

Test Plan:
- Reset, then LOADI R1=4'h5 and LOADI R2=4'h3 -> in_ready returns high 1 cycle after each accept; OUT R1 gives out_data=5, then OUT R2 gives out_data=3.
- ALU ADD (sel=3'b100, cin=0, rd=R3, ra=R1, rb=R2) with R1=5, R2=3 -> EXEC shows alu_a=5, alu_b=3; R3=8 two cycles after accept; OUT R3 -> 8.
- ALU SUB (sel=3'b010, cin=1) R0=R2-R1 with R2=3, R1=5 -> R0=4'hE (wrap); with ALU_SEQ_ZFLAG_EN, zero_flag=0. Then SUB R0=R1-R1 -> R0=0 and zero_flag=1.
- ALU AND (sel=3'b001, cin=0) then XOR (sel=3'b101, cin=0) on 4'hC and 4'hA -> results 4'h8 and 4'h6.
- OUT R3 with out_ready held low for 5 cycles -> out_valid stays high, out_data stable, in_ready=0 and in_valid ignored; out_ready=1 -> one transfer, then IDLE.
- Assert rst_n low during WB of an ALU op writing R1 -> R1 reads 0 after reset; out_valid=0; in_ready=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: control and operand stage for the BasicCPU 4-bit ALU.
// Accepts 12-bit instructions and keeps a 4 x 4-bit register file.
// Drives registered ALU operands, writes the ALU result back and streams
// OUT results downstream. Only one instruction is in flight at a time.
// Optional feature: define ALU_SEQ_ZFLAG_EN to build the zero-flag register.
// Without it, zero_flag is tied to 0.
module alu_sequencer #(
   parameter int DATA_W = 4,
   parameter int NREGS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [11:0]       instr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_s,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_f,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              zero_flag,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WB   = 2'd2;
   localparam logic [1:0] OUTW = 2'd3;

   localparam logic [1:0] K_ALU   = 2'b00;
   localparam logic [1:0] K_LOADI = 2'b01;
   localparam logic [1:0] K_OUT   = 2'b10;

   logic [1:0]        state;
   logic [1:0]        kind_q;
   logic [1:0]        rd_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] wr_data;

   // Field views of the incoming instruction word.
   logic [1:0] in_kind, in_ra, in_rb;
   assign in_kind = instr[11:10];
   assign in_ra   = instr[3:2];
   assign in_rb   = instr[1:0];

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // WB is only reached by ALU and LOADI, so anything else is LOADI here.
   assign wr_data = (kind_q == K_ALU) ? alu_f : imm_q;

   // Sequencer FSM, latched instruction fields, ALU operands and OUT handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         kind_q    <= 2'b00;
         rd_q      <= 2'b00;
         imm_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_s     <= 3'b000;
         alu_cin   <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         case (state)
            IDLE: begin
               if (in_valid) begin
                  kind_q <= in_kind;
                  rd_q   <= instr[5:4];
                  imm_q  <= instr[DATA_W-1:0];
                  case (in_kind)
                     K_ALU: begin
                        // Operands are captured at accept so they are stable
                        // throughout EXEC and keep their value afterwards.
                        alu_a   <= regs[in_ra];
                        alu_b   <= regs[in_rb];
                        alu_s   <= instr[9:7];
                        alu_cin <= instr[6];
                        state   <= EXEC;
                     end
                     K_LOADI: state <= WB;
                     K_OUT: begin
                        out_data  <= regs[in_rb];
                        out_valid <= 1'b1;
                        state     <= OUTW;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
            EXEC: state <= WB;
            WB:   state <= IDLE;
            OUTW: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Register file: written once, at the end of WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the register file is small and must read as zero after
         // reset, so it is reset like any other flop rather than left as RAM.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (state == WB) begin
         regs[rd_q] <= wr_data;
      end
   end

`ifdef ALU_SEQ_ZFLAG_EN
   // Zero flag follows the result of ALU-kind writes only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag <= 1'b0;
      end else if (state == WB && kind_q == K_ALU) begin
         zero_flag <= (alu_f == '0);
      end
   end
`else
   assign zero_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized bench for alu_sequencer.
// A small ALU model answers alu_f. A cycle-counting reference model runs at
// each falling edge and checks every output.
// Honors ALU_SEQ_ZFLAG_EN in the same way as the design.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] instr;
   logic [3:0]  alu_a, alu_b, alu_f, out_data;
   logic [2:0]  alu_s;
   logic        alu_cin;
   logic        out_valid, out_ready, zero_flag, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_cin(alu_cin), .alu_f(alu_f), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .zero_flag(zero_flag),
      .busy(busy)
   );

   // Stand-in ALU, keyed on the sequencer-side select code.
   function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s, input logic c);
      case (s)
         3'b000:  return a;
         3'b001:  return a & b;
         3'b010:  return a + ~b + {3'b000, c};
         3'b011:  return a | b;
         3'b100:  return a + b + {3'b000, c};
         3'b101:  return a ^ b;
         3'b110:  return ~a;
         default: return b;
      endcase
   endfunction

   assign alu_f = alu_fn(alu_a, alu_b, alu_s, alu_cin);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] i_alu(input logic [2:0] sel, input logic cin,
                                         input logic [1:0] rd, input logic [1:0] ra,
                                         input logic [1:0] rb);
      return {2'b00, sel, cin, rd, ra, rb};
   endfunction
   function automatic logic [11:0] i_ldi(input logic [1:0] rd, input logic [3:0] imm);
      return {2'b01, 3'b000, 1'b0, rd, imm};
   endfunction
   function automatic logic [11:0] i_out(input logic [1:0] rb);
      return {2'b10, 3'b000, 1'b0, 2'b00, 2'b00, rb};
   endfunction

   // Reference model state, owned by the compare process below.
   logic [3:0]  m_r [4];
   int          m_left;
   logic        m_out_busy;
   logic [3:0]  m_out;
   logic [11:0] m_pend;
   logic [3:0]  m_a, m_b;
   logic [2:0]  m_s;
   logic        m_cin;
   logic        m_z;

   // Compare and advance the model once per cycle, at the falling edge.
   always @(negedge clk) begin
      logic       rdy;
      logic [3:0] f;
      if (!rst_n) begin
         check("rst_in_ready", in_ready, 1);
         check("rst_busy", busy, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_data", out_data, 0);
         check("rst_alu_a", alu_a, 0);
         check("rst_alu_b", alu_b, 0);
         check("rst_alu_s", alu_s, 0);
         check("rst_alu_cin", alu_cin, 0);
         check("rst_zero_flag", zero_flag, 0);
         for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
         m_left = 0; m_out_busy = 1'b0; m_out = 4'h0; m_pend = 12'h000;
         m_a = 4'h0; m_b = 4'h0; m_s = 3'b000; m_cin = 1'b0; m_z = 1'b0;
      end else begin
         rdy = (m_left == 0) && !m_out_busy;
         check("in_ready", in_ready, rdy);
         check("busy", busy, !rdy);
         check("out_valid", out_valid, m_out_busy);
         if (m_out_busy) check("out_data", out_data, m_out);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("alu_s", alu_s, m_s);
         check("alu_cin", alu_cin, m_cin);
`ifdef ALU_SEQ_ZFLAG_EN
         check("zero_flag", zero_flag, m_z);
`else
         check("zero_flag", zero_flag, 0);
`endif
         // Pending writes land when the busy countdown expires.
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               if (m_pend[11:10] == 2'b00) begin
                  f = alu_fn(m_a, m_b, m_s, m_cin);
                  m_r[m_pend[5:4]] = f;
                  m_z = (f == 4'h0);
               end else begin
                  m_r[m_pend[5:4]] = m_pend[3:0];
               end
            end
         end
         if (m_out_busy && out_ready) m_out_busy = 1'b0;
         if (in_valid && rdy) begin
            case (instr[11:10])
               2'b00: begin
                  m_a = m_r[instr[3:2]]; m_b = m_r[instr[1:0]];
                  m_s = instr[9:7]; m_cin = instr[6];
                  m_left = 2; m_pend = instr;
               end
               2'b01: begin m_left = 1; m_pend = instr; end
               2'b10: begin m_out_busy = 1'b1; m_out = m_r[instr[1:0]]; end
               default: ;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction once the sequencer is ready; returns in the
   // cycle after the accepting edge.
   task automatic send(input logic [11:0] w);
      int n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      if (!in_ready) check("send_timeout", in_ready, 1);
      in_valid = 1'b1;
      instr    = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [3:0] exp);
      check({name, "_valid"}, out_valid, 1);
      check(name, out_data, exp);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; instr = 12'h000; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      rst_n = 1'b1;
      tick();

      // LOADI then OUT.
      send(i_ldi(2'd1, 4'h5));
      check("ldi_wb_not_ready", in_ready, 0);
      tick();
      check("ldi_ready_after_1", in_ready, 1);
      send(i_ldi(2'd2, 4'h3));
      send(i_out(2'd1));
      expect_out("out_r1", 4'h5);
      send(i_out(2'd2));
      expect_out("out_r2", 4'h3);

      // ADD R3 = R1 + R2.
      send(i_alu(3'b100, 1'b0, 2'd3, 2'd1, 2'd2));
      check("add_exec_a", alu_a, 4'h5);
      check("add_exec_b", alu_b, 4'h3);
      check("add_exec_s", alu_s, 3'b100);
      send(i_out(2'd3));
      expect_out("add_r3", 4'h8);

      // SUB with wrap, then SUB to zero.
      send(i_alu(3'b010, 1'b1, 2'd0, 2'd2, 2'd1));
      send(i_out(2'd0));
      expect_out("sub_wrap", 4'hE);
`ifdef ALU_SEQ_ZFLAG_EN
      check("sub_wrap_zflag", zero_flag, 0);
`endif
      send(i_alu(3'b010, 1'b1, 2'd0, 2'd1, 2'd1));
      send(i_out(2'd0));
      expect_out("sub_zero", 4'h0);
`ifdef ALU_SEQ_ZFLAG_EN
      check("sub_zero_zflag", zero_flag, 1);
      send(i_ldi(2'd0, 4'h9));
      check("ldi_keeps_zflag", zero_flag, 1);
`endif

      // AND / XOR on C and A.
      send(i_ldi(2'd1, 4'hC));
      send(i_ldi(2'd2, 4'hA));
      send(i_alu(3'b001, 1'b0, 2'd3, 2'd1, 2'd2));
      send(i_out(2'd3));
      expect_out("and_r3", 4'h8);
      send(i_alu(3'b101, 1'b0, 2'd3, 2'd1, 2'd2));
      send(i_out(2'd3));
      expect_out("xor_r3", 4'h6);

      // OUT stall with a competing instruction that must be ignored.
      send(12'hC00);
      check("nop_ready", in_ready, 1);
      out_ready = 1'b0;
      send(i_out(2'd3));
      in_valid = 1'b1;
      instr    = i_ldi(2'd3, 4'hF);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, 4'h6);
         check("stall_in_ready", in_ready, 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("stall_done_valid", out_valid, 0);
      check("stall_done_ready", in_ready, 1);
      send(i_out(2'd3));
      expect_out("stall_ignored", 4'h6);

      // Reset during WB of an ALU op writing R1.
      send(i_ldi(2'd1, 4'h7));
      send(i_alu(3'b100, 1'b0, 2'd1, 2'd1, 2'd1));
      tick();
      check("wb_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      tick();
      send(i_out(2'd1));
      expect_out("midrst_r1", 4'h0);

      // Randomized traffic, with backpressure and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst_n     = ($urandom_range(0, 299) != 0);
         in_valid  = $urandom_range(0, 1);
         instr     = 12'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
